// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared types and helpers for the pipeline hazard controller
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic pc_ena;
    logic if_id_ena;
    logic if_id_flush;
    logic id_ex_ena;
    logic id_ex_flush;
    logic ex_mem_ena;
    logic mem_wb_ena;
  } ctrl_t;

  localparam ctrl_t CTRL_FREEZE = '0;

  // Control word when memory is not holding the pipe: redirect beats load-use,
  // because on a redirect the instruction in ID is wrong-path anyway.
  function automatic ctrl_t run_ctrl(input logic pc_sel, input logic load_use);
    ctrl_t c;
    c.pc_ena      = 1'b1;
    c.if_id_ena   = 1'b1;
    c.if_id_flush = 1'b0;
    c.id_ex_ena   = 1'b1;
    c.id_ex_flush = 1'b0;
    c.ex_mem_ena  = 1'b1;
    c.mem_wb_ena  = 1'b1;
    if (pc_sel) begin
      c.if_id_flush = 1'b1;
      c.id_ex_flush = 1'b1;
    end else if (load_use) begin
      c.pc_ena      = 1'b0;
      c.if_id_ena   = 1'b0;
      c.id_ex_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard inputs and pipeline register controls
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ID_RS1;
  logic [4:0]       ID_RS2;
  logic             ID_USE_RS1;
  logic             ID_USE_RS2;
  logic [4:0]       EX_RD;
  logic             EX_MEM_READ;
  logic             PC_SEL;
  logic             DMEM_REQ;
  logic             DMEM_READY;
  logic             PC_ENA;
  logic             IF_ID_ENA;
  logic             IF_ID_FLUSH;
  logic             ID_EX_ENA;
  logic             ID_EX_FLUSH;
  logic             EX_MEM_ENA;
  logic             MEM_WB_ENA;
  logic             ERR;
  logic [CNT_W-1:0] STALL_CNT;
  logic [CNT_W-1:0] FLUSH_CNT;

  modport master (
    output ID_RS1, ID_RS2, ID_USE_RS1, ID_USE_RS2, EX_RD, EX_MEM_READ,
           PC_SEL, DMEM_REQ, DMEM_READY,
    input  PC_ENA, IF_ID_ENA, IF_ID_FLUSH, ID_EX_ENA, ID_EX_FLUSH,
           EX_MEM_ENA, MEM_WB_ENA, ERR, STALL_CNT, FLUSH_CNT
  );

  modport slave (
    input  ID_RS1, ID_RS2, ID_USE_RS1, ID_USE_RS2, EX_RD, EX_MEM_READ,
           PC_SEL, DMEM_REQ, DMEM_READY,
    output PC_ENA, IF_ID_ENA, IF_ID_FLUSH, ID_EX_ENA, ID_EX_FLUSH,
           EX_MEM_ENA, MEM_WB_ENA, ERR, STALL_CNT, FLUSH_CNT
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// rtl/pipeline_hazard_ctrl_sat_counter.sv - saturating event counter
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         INC,
  output logic [W-1:0] CNT
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Advance on INC but stick at all-ones rather than wrapping
  always_comb begin
    cnt_d = cnt_q;
    if (INC && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  // Count register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign CNT = cnt_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer with memory watchdog and perf counters
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W          = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int                WAIT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  ctrl_t             ctrl;
  logic              load_use;
  logic              mem_stall;
  logic              stall_inc;
  logic              flush_inc;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  // Hazard detection on the current ID/EX/MEM contents
  always_comb begin
    load_use  = hz.EX_MEM_READ && (hz.EX_RD != REG_X0) &&
                ((hz.ID_USE_RS1 && (hz.ID_RS1 == hz.EX_RD)) ||
                 (hz.ID_USE_RS2 && (hz.ID_RS2 == hz.EX_RD)));
    mem_stall = hz.DMEM_REQ && !hz.DMEM_READY;
  end

  // Next state, watchdog count and same-cycle pipeline controls
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ctrl    = CTRL_FREEZE;
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end else begin
          ctrl = run_ctrl(hz.PC_SEL, load_use);
        end
      end
      MEM_WAIT: begin
        if (!hz.DMEM_READY) begin
          wait_d = wait_q + WAIT_W'(1);
          if (wait_d >= WAIT_LIMIT) state_d = ERROR;
        end else begin
          ctrl    = run_ctrl(hz.PC_SEL, load_use);
          state_d = RUN;
          wait_d  = '0;
        end
      end
      ERROR: begin
        ctrl = CTRL_FREEZE;
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase
    if (RESET) ctrl = CTRL_FREEZE;
  end

  // State and watchdog registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Counter events; cycles spent in ERROR are not pipeline stalls
  always_comb begin
    stall_inc = !ctrl.pc_ena && (state_q != ERROR) && !RESET;
    flush_inc = ctrl.if_id_flush;
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .INC   (stall_inc),
    .CNT   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .INC   (flush_inc),
    .CNT   (flush_cnt)
  );

  assign hz.PC_ENA      = ctrl.pc_ena;
  assign hz.IF_ID_ENA   = ctrl.if_id_ena;
  assign hz.IF_ID_FLUSH = ctrl.if_id_flush;
  assign hz.ID_EX_ENA   = ctrl.id_ex_ena;
  assign hz.ID_EX_FLUSH = ctrl.id_ex_flush;
  assign hz.EX_MEM_ENA  = ctrl.ex_mem_ena;
  assign hz.MEM_WB_ENA  = ctrl.mem_wb_ena;
  assign hz.ERR         = (state_q == ERROR);
  assign hz.STALL_CNT   = stall_cnt;
  assign hz.FLUSH_CNT   = flush_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
  // {PC_ENA, IF_ID_ENA, IF_ID_FLUSH, ID_EX_ENA, ID_EX_FLUSH, EX_MEM_ENA, MEM_WB_ENA}
  localparam logic [6:0] C_RUN    = 7'b1101011;
  localparam logic [6:0] C_FREEZE = 7'b0000000;
  localparam logic [6:0] C_REDIR  = 7'b1111111;
  localparam logic [6:0] C_LDUSE  = 7'b0001111;

  logic CLK;
  logic RESET;
  int   errors = 0;
  int   checks = 0;

  pipeline_hazard_ctrl_if #(.CNT_W(4)) hz_if ();

  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .hz    (hz_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctrl(input string tag, input logic [6:0] exp);
    chk(tag, {9'd0, hz_if.PC_ENA, hz_if.IF_ID_ENA, hz_if.IF_ID_FLUSH, hz_if.ID_EX_ENA,
              hz_if.ID_EX_FLUSH, hz_if.EX_MEM_ENA, hz_if.MEM_WB_ENA}, {9'd0, exp});
  endtask

  task automatic clear_inputs;
    hz_if.ID_RS1 = 5'd0;  hz_if.ID_RS2 = 5'd0;
    hz_if.ID_USE_RS1 = 1'b0; hz_if.ID_USE_RS2 = 1'b0;
    hz_if.EX_RD = 5'd0;   hz_if.EX_MEM_READ = 1'b0;
    hz_if.PC_SEL = 1'b0;  hz_if.DMEM_REQ = 1'b0; hz_if.DMEM_READY = 1'b0;
  endtask

  task automatic do_reset;
    RESET = 1'b1;
    clear_inputs();
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    clear_inputs();
    tick();
    // Reset state
    #1;
    chk_ctrl("reset_ctrl", C_FREEZE);
    chk("reset_err", {15'd0, hz_if.ERR}, 16'd0);
    chk("reset_stall", {12'd0, hz_if.STALL_CNT}, 16'd0);
    chk("reset_flush", {12'd0, hz_if.FLUSH_CNT}, 16'd0);
    RESET = 1'b0;
    #1 chk_ctrl("post_reset_run", C_RUN);

    // Reset asserted while in MEM_WAIT
    hz_if.DMEM_REQ = 1'b1;
    #1 chk_ctrl("memw_enter", C_FREEZE);
    tick();
    chk("memw_stall1", {12'd0, hz_if.STALL_CNT}, 16'd1);
    RESET = 1'b1;
    #1;
    chk_ctrl("rst_mid_wait_ctrl", C_FREEZE);
    chk("rst_mid_wait_stall", {12'd0, hz_if.STALL_CNT}, 16'd0);
    tick();
    RESET = 1'b0;
    hz_if.DMEM_REQ = 1'b0;
    #1;
    chk_ctrl("rst_mid_wait_run", C_RUN);
    chk("rst_mid_wait_cnt", {12'd0, hz_if.STALL_CNT}, 16'd0);
    tick();

    // Load-use via rs2
    hz_if.EX_MEM_READ = 1'b1; hz_if.EX_RD = 5'd5;
    hz_if.ID_RS2 = 5'd5;      hz_if.ID_USE_RS2 = 1'b1;
    #1 chk_ctrl("lduse_rs2", C_LDUSE);
    tick();
    hz_if.EX_MEM_READ = 1'b0;
    #1;
    chk_ctrl("lduse_after", C_RUN);
    chk("lduse_stall", {12'd0, hz_if.STALL_CNT}, 16'd1);
    chk("lduse_flush", {12'd0, hz_if.FLUSH_CNT}, 16'd0);
    // Same stimulus targeting x0: no hazard
    hz_if.EX_MEM_READ = 1'b1; hz_if.EX_RD = 5'd0; hz_if.ID_RS2 = 5'd0;
    #1 chk_ctrl("lduse_x0", C_RUN);
    tick();
    clear_inputs();
    // Load-use via rs1, then the same match with the read disabled
    hz_if.EX_MEM_READ = 1'b1; hz_if.EX_RD = 5'd7;
    hz_if.ID_RS1 = 5'd7;      hz_if.ID_USE_RS1 = 1'b1;
    #1 chk_ctrl("lduse_rs1", C_LDUSE);
    tick();
    hz_if.ID_USE_RS1 = 1'b0;
    #1 chk_ctrl("lduse_rs1_unused", C_RUN);
    tick();
    chk("lduse_stall2", {12'd0, hz_if.STALL_CNT}, 16'd2);

    // Branch with simultaneous load-use
    do_reset();
    hz_if.PC_SEL = 1'b1;
    hz_if.EX_MEM_READ = 1'b1; hz_if.EX_RD = 5'd5;
    hz_if.ID_RS2 = 5'd5;      hz_if.ID_USE_RS2 = 1'b1;
    #1 chk_ctrl("br_lduse", C_REDIR);
    tick();
    clear_inputs();
    #1;
    chk("br_flush", {12'd0, hz_if.FLUSH_CNT}, 16'd1);
    chk("br_stall", {12'd0, hz_if.STALL_CNT}, 16'd0);

    // Memory wait of three cycles with a redirect pending
    do_reset();
    hz_if.DMEM_REQ = 1'b1; hz_if.PC_SEL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk_ctrl($sformatf("memw_freeze%0d", i), C_FREEZE);
      tick();
    end
    hz_if.DMEM_READY = 1'b1;
    #1 chk_ctrl("memw_ready", C_REDIR);
    tick();
    clear_inputs();
    #1;
    chk_ctrl("memw_resume", C_RUN);
    chk("memw_stall", {12'd0, hz_if.STALL_CNT}, 16'd3);
    chk("memw_flush", {12'd0, hz_if.FLUSH_CNT}, 16'd1);
    chk("memw_err", {15'd0, hz_if.ERR}, 16'd0);

    // Timeout with READY never asserted
    do_reset();
    hz_if.DMEM_REQ = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    #1 chk("to_err_before", {15'd0, hz_if.ERR}, 16'd0);
    tick();
    #1;
    chk("to_err", {15'd0, hz_if.ERR}, 16'd1);
    chk_ctrl("to_ctrl", C_FREEZE);
    hz_if.DMEM_READY = 1'b1; hz_if.PC_SEL = 1'b1;
    tick();
    tick();
    #1;
    chk("to_sticky", {15'd0, hz_if.ERR}, 16'd1);
    chk_ctrl("to_sticky_ctrl", C_FREEZE);
    chk("to_stall", {12'd0, hz_if.STALL_CNT}, 16'd4);
    chk("to_flush", {12'd0, hz_if.FLUSH_CNT}, 16'd0);
    do_reset();
    #1 chk("to_cleared", {15'd0, hz_if.ERR}, 16'd0);

    // READY on the fourth wait cycle avoids the timeout
    hz_if.DMEM_REQ = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    hz_if.DMEM_READY = 1'b1;
    #1 chk_ctrl("to_edge_ready", C_RUN);
    tick();
    clear_inputs();
    #1;
    chk("to_edge_err", {15'd0, hz_if.ERR}, 16'd0);
    chk_ctrl("to_edge_run", C_RUN);
    chk("to_edge_stall", {12'd0, hz_if.STALL_CNT}, 16'd3);

    // Stall counter saturation
    do_reset();
    hz_if.EX_MEM_READ = 1'b1; hz_if.EX_RD = 5'd9;
    hz_if.ID_RS1 = 5'd9;      hz_if.ID_USE_RS1 = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    #1 chk("sat_14", {12'd0, hz_if.STALL_CNT}, 16'd14);
    for (int i = 0; i < 6; i++) tick();
    clear_inputs();
    #1 chk("sat_15", {12'd0, hz_if.STALL_CNT}, 16'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
